// File: rtl/motor_sequencer_if.sv
// Command handshake between the command decoder and the motor sequencer.
// The decoder drives the command fields; the sequencer answers with ready.
interface motor_sequencer_if;
  logic        valid;
  logic        ready;
  logic        stop;
  logic        dir;
  logic [15:0] duty;

  modport master (output valid, output stop, output dir, output duty, input ready);
  modport slave  (input valid, input stop, input dir, input duty, output ready);
endinterface

// File: rtl/motor_sequencer.sv
// Command-level motor controller: power-up settle, ramped duty changes, brake on
// reversal/stop and latched fault shutdown, driving the motor control word and PWM duty.
module motor_sequencer #(
  parameter int unsigned PwmPeriod   = 1000,
  parameter int unsigned RampStep    = 10,
  parameter int unsigned RampDiv     = 500,
  parameter int unsigned PwrSettle   = 5000,
  parameter int unsigned BrakeCycles = 5000
) (
  input  logic                clk,
  input  logic                rst,
  motor_sequencer_if.slave    cmd,
  input  logic                fault,
  input  logic                clr_fault,
  output logic [3:0]          m_c,
  output logic [15:0]         count_value,
  output logic [15:0]         duty_value,
  output logic [2:0]          state,
  output logic                busy
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPwrOn  = 3'd1,
    StRamp   = 3'd2,
    StRun    = 3'd3,
    StRampDn = 3'd4,
    StBrake  = 3'd5,
    StFault  = 3'd6
  } state_e;

  localparam logic [15:0] Period16   = 16'(PwmPeriod);
  localparam logic [15:0] Step16     = 16'(RampStep);
  localparam logic [15:0] TickLast   = 16'(RampDiv - 1);
  localparam logic [15:0] SettleLast = 16'(PwrSettle - 1);
  localparam logic [15:0] BrakeLast  = 16'(BrakeCycles - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] tgt_q, tgt_d;
  logic        cur_dir_q, cur_dir_d;
  logic        next_dir_q, next_dir_d;
  logic        stop_pend_q, stop_pend_d;

  logic        accept;
  logic        ramp_tick;
  logic [15:0] clamped;
  logic [15:0] ramp_tgt;
  logic [15:0] stepped;

  assign cmd.ready   = ((state_q == StIdle) || (state_q == StRun)) && !fault;
  assign accept      = cmd.valid && cmd.ready;
  assign clamped     = (cmd.duty > Period16) ? Period16 : cmd.duty;
  assign ramp_tick   = (cnt_q == TickLast);
  assign ramp_tgt    = (state_q == StRamp) ? tgt_q : 16'd0;
  assign count_value = Period16;
  assign duty_value  = duty_q;
  assign state       = state_q;
  assign busy        = (state_q != StIdle) && (state_q != StRun);

  // One ramp step toward the active target, landing exactly on it when close.
  always_comb begin
    stepped = ramp_tgt;
    if (ramp_tgt > duty_q) begin
      if ((ramp_tgt - duty_q) > Step16) stepped = duty_q + Step16;
    end else begin
      if ((duty_q - ramp_tgt) > Step16) stepped = duty_q - Step16;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    duty_d      = duty_q;
    tgt_d       = tgt_q;
    cur_dir_d   = cur_dir_q;
    next_dir_d  = next_dir_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      StIdle: begin
        duty_d = '0;
        if (accept && !cmd.stop) begin
          cur_dir_d  = cmd.dir;
          next_dir_d = cmd.dir;
          tgt_d      = clamped;
          state_d    = StPwrOn;
        end
      end
      StPwrOn: begin
        if (cnt_q == SettleLast) state_d = StRamp;
      end
      StRamp: begin
        if (duty_q == tgt_q) begin
          state_d = StRun;
        end else if (ramp_tick) begin
          duty_d = stepped;
          cnt_d  = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (cmd.stop) begin
            stop_pend_d = 1'b1;
            state_d     = StRampDn;
          end else if (cmd.dir != cur_dir_q) begin
            next_dir_d = cmd.dir;
            tgt_d      = clamped;
            state_d    = StRampDn;
          end else begin
            tgt_d   = clamped;
            state_d = StRamp;
          end
        end
      end
      StRampDn: begin
        if (duty_q == 16'd0) begin
          state_d = StBrake;
        end else if (ramp_tick) begin
          duty_d = stepped;
          cnt_d  = '0;
        end
      end
      StBrake: begin
        duty_d = '0;
        if (cnt_q == BrakeLast) begin
          if (stop_pend_q) begin
            stop_pend_d = 1'b0;
            state_d     = StIdle;
          end else begin
            cur_dir_d = next_dir_q;
            state_d   = StRamp;
          end
        end
      end
      StFault: begin
        duty_d = '0;
        if (clr_fault && !fault) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Fault overrides everything, including a command accepted this cycle.
    if (fault) begin
      state_d     = StFault;
      duty_d      = '0;
      stop_pend_d = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      duty_q      <= '0;
      tgt_q       <= '0;
      cur_dir_q   <= 1'b0;
      next_dir_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      tgt_q       <= tgt_d;
      cur_dir_q   <= cur_dir_d;
      next_dir_q  <= next_dir_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Control word is a pure decode of registered state and direction.
  always_comb begin
    m_c = 4'b0000;
    case (state_q)
      StPwrOn:                 m_c = {1'b1, 1'b1, 1'b0, cur_dir_q};
      StRamp, StRun, StRampDn: m_c = {1'b1, 1'b1, 1'b1, cur_dir_q};
      StBrake:                 m_c = {1'b1, 1'b0, 1'b1, cur_dir_q};
      default:                 m_c = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// Bench for motor_sequencer: directed vector table plus random commands checked every
// cycle against a trajectory model that expands each command into its expected outputs.
module tb_motor_sequencer;
  localparam int unsigned PwmPeriod   = 1000;
  localparam int unsigned RampStep    = 100;
  localparam int unsigned RampDiv     = 4;
  localparam int unsigned PwrSettle   = 8;
  localparam int unsigned BrakeCycles = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault = 1'b0;
  logic        clr_fault = 1'b0;
  logic [3:0]  m_c;
  logic [15:0] count_value;
  logic [15:0] duty_value;
  logic [2:0]  state;
  logic        busy;

  int tests = 0;
  int fails = 0;

  motor_sequencer_if cmd_if ();

  motor_sequencer #(
    .PwmPeriod  (PwmPeriod),
    .RampStep   (RampStep),
    .RampDiv    (RampDiv),
    .PwrSettle  (PwrSettle),
    .BrakeCycles(BrakeCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd_if),
    .fault      (fault),
    .clr_fault  (clr_fault),
    .m_c        (m_c),
    .count_value(count_value),
    .duty_value (duty_value),
    .state      (state),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // ---------------- trajectory model ----------------
  typedef struct packed {
    logic [2:0]  st;
    logic        dir;
    logic [15:0] duty;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t settled;
  logic m_dir;

  function automatic logic [3:0] mc_for(input logic [2:0] st, input logic dir);
    case (st)
      3'd1:             return {3'b110, dir};
      3'd2, 3'd3, 3'd4: return {3'b111, dir};
      3'd5:             return {3'b101, dir};
      default:          return 4'b0000;
    endcase
  endfunction

  function automatic int step_toward(input int d, input int to);
    if (to > d) return (to - d <= int'(RampStep)) ? to : d + int'(RampStep);
    return (d - to <= int'(RampStep)) ? to : d - int'(RampStep);
  endfunction

  function automatic exp_t mk(input int st, input logic dir, input int duty);
    exp_t e;
    e.st   = 3'(st);
    e.dir  = dir;
    e.duty = 16'(duty);
    return e;
  endfunction

  // Entry cycle shows the old duty; each step holds RampDiv cycles.
  task automatic gen_ramp(input int st, input logic dir, input int from, input int to);
    int d;
    d = from;
    q.push_back(mk(st, dir, d));
    while (d != to) begin
      repeat (RampDiv - 1) q.push_back(mk(st, dir, d));
      d = step_toward(d, to);
      q.push_back(mk(st, dir, d));
    end
  endtask

  task automatic gen_brake(input logic dir);
    repeat (BrakeCycles) q.push_back(mk(5, dir, 0));
  endtask

  task automatic model_edge();
    int t;
    if (rst) begin
      q.delete();
      settled = mk(0, 1'b0, 0);
      cur     = settled;
      m_dir   = 1'b0;
    end else if (fault) begin
      q.delete();
      settled = mk(6, 1'b0, 0);
      cur     = settled;
    end else if (cur.st == 3'd6) begin
      if (clr_fault) begin
        settled = mk(0, 1'b0, 0);
        cur     = settled;
      end
    end else if (cmd_if.valid && (cur.st == 3'd0 || cur.st == 3'd3)) begin
      t = (int'(cmd_if.duty) > int'(PwmPeriod)) ? int'(PwmPeriod) : int'(cmd_if.duty);
      if (cur.st == 3'd0) begin
        if (!cmd_if.stop) begin
          repeat (PwrSettle) q.push_back(mk(1, cmd_if.dir, 0));
          gen_ramp(2, cmd_if.dir, 0, t);
          m_dir   = cmd_if.dir;
          settled = mk(3, m_dir, t);
        end
      end else if (cmd_if.stop) begin
        gen_ramp(4, m_dir, int'(cur.duty), 0);
        gen_brake(m_dir);
        settled = mk(0, 1'b0, 0);
      end else if (cmd_if.dir != m_dir) begin
        gen_ramp(4, m_dir, int'(cur.duty), 0);
        gen_brake(m_dir);
        gen_ramp(2, cmd_if.dir, 0, t);
        m_dir   = cmd_if.dir;
        settled = mk(3, m_dir, t);
      end else begin
        gen_ramp(2, m_dir, int'(cur.duty), t);
        settled = mk(3, m_dir, t);
      end
      cur = (q.size() > 0) ? q.pop_front() : settled;
    end else begin
      cur = (q.size() > 0) ? q.pop_front() : settled;
    end
  endtask

  task automatic model_check();
    logic [3:0] emc;
    logic       erdy;
    logic       ebusy;
    emc   = mc_for(cur.st, cur.dir);
    erdy  = (cur.st == 3'd0 || cur.st == 3'd3) && !fault;
    ebusy = !(cur.st == 3'd0 || cur.st == 3'd3);
    tests++;
    if (state !== cur.st || m_c !== emc || duty_value !== cur.duty || cmd_if.ready !== erdy ||
        busy !== ebusy || count_value !== 16'(PwmPeriod)) begin
      fails++;
      $display("FAIL model t=%0t: got st=%0d mc=%b duty=%0d rdy=%b busy=%b cnt=%0d, want st=%0d mc=%b duty=%0d rdy=%b busy=%b cnt=%0d",
               $time, state, m_c, duty_value, cmd_if.ready, busy, count_value,
               cur.st, emc, cur.duty, erdy, ebusy, PwmPeriod);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        valid;
    logic        stop;
    logic        dir;
    logic [15:0] duty;
    logic        flt;
    logic        clr;
    int          wait_n;
    logic [2:0]  st;
    logic [3:0]  mc;
    logic [15:0] dty;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic s, input logic d,
                     input int du, input logic f, input logic c, input int w,
                     input int st, input logic [3:0] mc, input int dty, input logic rdy);
    vec_t x;
    x.rst = r; x.valid = v; x.stop = s; x.dir = d; x.duty = 16'(du);
    x.flt = f; x.clr = c; x.wait_n = w;
    x.st = 3'(st); x.mc = mc; x.dty = 16'(dty); x.rdy = rdy;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic d,
                       input logic [15:0] du, input logic f, input logic c);
    rst = r; cmd_if.valid = v; cmd_if.stop = s; cmd_if.dir = d; cmd_if.duty = du;
    fault = f; clr_fault = c;
  endtask

  initial begin
    int fault_left;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    settled = mk(0, 1'b0, 0);
    cur     = settled;
    m_dir   = 1'b0;

    //  rst v  s  d  duty  f  c  wait  st  mc       duty  rdy
    add(1, 0, 0, 0, 0,    0, 0, 0,    0, 4'b0000, 0,    1);  // reset
    add(0, 1, 0, 1, 350,  0, 0, 0,    1, 4'b1101, 0,    0);  // start-up: PWR
    add(0, 0, 0, 0, 0,    0, 0, 6,    1, 4'b1101, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 0,    2, 4'b1111, 0,    0);  // EN 8 later
    add(0, 0, 0, 0, 0,    0, 0, 3,    2, 4'b1111, 100,  0);
    add(0, 0, 0, 0, 0,    0, 0, 11,   2, 4'b1111, 350,  0);
    add(0, 0, 0, 0, 0,    0, 0, 0,    3, 4'b1111, 350,  1);
    add(0, 1, 0, 1, 5000, 0, 0, 0,    2, 4'b1111, 350,  0);  // clamp
    add(0, 0, 0, 0, 0,    0, 0, 27,   2, 4'b1111, 1000, 0);
    add(0, 0, 0, 0, 0,    0, 0, 0,    3, 4'b1111, 1000, 1);
    add(0, 1, 0, 1, 250,  0, 0, 28,   2, 4'b1111, 300,  0);  // retarget down
    add(0, 0, 0, 0, 0,    0, 0, 3,    2, 4'b1111, 250,  0);
    add(0, 0, 0, 0, 0,    0, 0, 0,    3, 4'b1111, 250,  1);
    add(0, 1, 0, 1, 300,  0, 0, 0,    2, 4'b1111, 250,  0);
    add(0, 0, 0, 0, 0,    0, 0, 5,    3, 4'b1111, 300,  1);
    add(0, 1, 0, 0, 300,  0, 0, 0,    4, 4'b1111, 300,  0);  // reversal
    add(0, 0, 0, 0, 0,    0, 0, 11,   4, 4'b1111, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 0,    5, 4'b1011, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 9,    2, 4'b1110, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 12,   3, 4'b1110, 300,  1);
    add(0, 1, 0, 0, 200,  0, 0, 5,    3, 4'b1110, 200,  1);
    add(0, 1, 1, 0, 0,    0, 0, 0,    4, 4'b1110, 200,  0);  // stop
    add(0, 0, 0, 0, 0,    0, 0, 9,    5, 4'b1010, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 10,   0, 4'b0000, 0,    1);
    add(0, 1, 1, 1, 500,  0, 0, 2,    0, 4'b0000, 0,    1);  // stop in idle
    add(0, 1, 0, 1, 500,  0, 0, 9,    2, 4'b1111, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 3,    2, 4'b1111, 100,  0);
    add(0, 0, 0, 0, 0,    1, 0, 0,    6, 4'b0000, 0,    0);  // fault in ramp
    add(0, 0, 0, 0, 0,    1, 1, 0,    6, 4'b0000, 0,    0);  // clear ignored
    add(0, 0, 0, 0, 0,    0, 1, 0,    0, 4'b0000, 0,    1);
    add(0, 1, 0, 1, 300,  1, 0, 0,    6, 4'b0000, 0,    0);  // fault beats cmd
    add(0, 0, 0, 0, 0,    0, 1, 0,    0, 4'b0000, 0,    1);
    add(0, 0, 0, 0, 0,    0, 0, 3,    0, 4'b0000, 0,    1);
    add(0, 1, 0, 1, 100,  0, 0, 0,    1, 4'b1101, 0,    0);
    add(0, 0, 0, 0, 0,    0, 0, 13,   3, 4'b1111, 100,  1);
    add(0, 1, 1, 1, 0,    0, 0, 0,    4, 4'b1111, 100,  0);
    add(0, 0, 0, 0, 0,    0, 0, 5,    5, 4'b1011, 0,    0);
    add(1, 0, 0, 0, 0,    0, 0, 0,    0, 4'b0000, 0,    1);  // reset mid-brake
    add(0, 1, 0, 0, 0,    0, 0, 9,    3, 4'b1110, 0,    1);  // zero target runs

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].stop, vecs[i].dir, vecs[i].duty,
            vecs[i].flt, vecs[i].clr);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
      repeat (vecs[i].wait_n) tick();
      tests++;
      if (state !== vecs[i].st || m_c !== vecs[i].mc || duty_value !== vecs[i].dty ||
          cmd_if.ready !== vecs[i].rdy) begin
        fails++;
        $display("FAIL vec%0d: got st=%0d mc=%b duty=%0d rdy=%b, want st=%0d mc=%b duty=%0d rdy=%b",
                 i, state, m_c, duty_value, cmd_if.ready,
                 vecs[i].st, vecs[i].mc, vecs[i].dty, vecs[i].rdy);
      end
    end

    // Random commands, faults and resets against the trajectory model.
    fault_left = 0;
    for (int n = 0; n < 5000; n++) begin
      if (fault_left > 0) fault_left--;
      else if ($urandom_range(0, 399) == 0) fault_left = $urandom_range(1, 3);
      drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom_range(0, 1200)),
            (fault_left > 0), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motor_sequencer.md
# motor_sequencer

Command-level controller for the motor-control block. Accepts speed/direction/stop commands over a valid/ready handshake and drives the motor control word (FWDREV, EN, BR, PWR), PWM period and PWM duty. It enforces a safe power-up delay, ramped duty changes, a brake interval on direction reversal and stop, and a latched fault shutdown. It sits between the command decoder and the motor-control/PWM stage.

## Interface
- PWM_PERIOD, 16'd1000, constant driven on COUNT_VALUE; upper bound for duty
- RAMP_STEP, 16'd10, duty increment/decrement per ramp tick
- RAMP_DIV, 16'd500, CLK cycles per ramp tick (≥1)
- PWR_SETTLE, 16'd5000, cycles with PWR=1 before EN is asserted (≥1)
- BRAKE_CYCLES, 16'd5000, cycles held in brake (≥1)

- CLK  in  1  system clock, 50 MHz
- RST  in  1  synchronous reset, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY at rising CLK
- CMD_STOP  in  1  1 = controlled stop and power-down; CMD_DIR/CMD_DUTY ignored
- CMD_DIR  in  1  requested FWDREV value
- CMD_DUTY  in  16  requested target duty
- FAULT  in  1  driver fault, active-high
- CLR_FAULT  in  1  single-cycle fault clear
- M_C  out  4  [0] FWDREV, [1] EN, [2] BR (0 = brake), [3] PWR
- COUNT_VALUE  out  16  = PWM_PERIOD at all times
- DUTY_VALUE  out  16  current ramped duty
- STATE  out  3  current state encoding
- BUSY  out  1  1 when STATE ∉ {IDLE, RUN}

## Operation
- States, encoding: IDLE=0, PWR_ON=1, RAMP=2, RUN=3, RAMP_DN=4, BRAKE=5, FAULT=6.
- Registers: cur_dir, tgt_duty, next_dir, stop_pend, 16-bit cycle counter, 16-bit duty.
- Accept: target clamped, tgt_duty = min(CMD_DUTY, PWM_PERIOD). CMD_READY = 1 only in IDLE and RUN, and never while FAULT=1.
- IDLE: M_C=0000, duty 0. Accept with CMD_STOP=1: no effect. Accept with CMD_STOP=0: latch dir/target, go PWR_ON.
- PWR_ON: M_C = {PWR=1, BR=1, EN=0, FWDREV=cur_dir}; after PWR_SETTLE cycles go RAMP.
- RAMP: EN=1, BR=1, PWR=1. On each ramp tick (every RAMP_DIV cycles in state), duty moves toward tgt_duty by RAMP_STEP without overshoot: if |tgt−duty| ≤ RAMP_STEP then duty=tgt. Go RUN in the cycle after duty==tgt_duty.
- RUN: outputs as RAMP, duty constant. Accept, same dir, not stop: new target, go RAMP (ramps up or down). Accept, opposite dir: next_dir latched, go RAMP_DN. Accept with stop: stop_pend=1, go RAMP_DN.
- RAMP_DN: ramp toward 0 at the same rate. Go BRAKE in the cycle after duty reaches 0.
- BRAKE: BR=0, EN=1, PWR=1, duty 0, held BRAKE_CYCLES cycles. Then: if stop_pend, clear it and go IDLE (PWR=0). Else cur_dir=next_dir and go RAMP toward the latched target.
- FAULT: from any state, FAULT=1 goes to FAULT on the next edge. Entry forces M_C=0000 and duty=0; FAULT has priority over command accept in the same cycle. Exit to IDLE only on CLR_FAULT=1 with FAULT=0; CLR_FAULT is ignored otherwise.
- Counter cleared on every state change and on every ramp tick.

## Timing
- All outputs are registered; M_C/DUTY_VALUE change on the edge that enters or acts in a state.
- Reset values: state IDLE, M_C=4'b0000, DUTY_VALUE=0, COUNT_VALUE=PWM_PERIOD, CMD_READY=1, BUSY=0, STATE=0, all internal registers 0.
- Accept in IDLE at edge N: PWR=1 from edge N+1; EN=1 from edge N+1+PWR_SETTLE.
- First ramp step lands RAMP_DIV cycles after RAMP entry.
- Ramp-up from 0 to T takes ceil(T/RAMP_STEP)·RAMP_DIV cycles, plus 1 cycle into RUN.
- RST mid-operation: everything returns to reset values on the next edge, including inside FAULT.
- Target of 0 in RUN ramps to 0 and stays in RUN with EN=1; only a stop command powers down.

## Test plan
Parameters for all scenarios: PWM_PERIOD=1000, RAMP_STEP=100, RAMP_DIV=4, PWR_SETTLE=8, BRAKE_CYCLES=10.
- Start-up: accept dir=1, duty=350 in IDLE. PWR rises 1 cycle later, EN rises 8 cycles after that. Duty steps 100, 200, 300, 350, one step every 4 cycles. Then RUN, M_C=4'b1111.
- Clamp and retarget: command duty=5000 gives target 1000. In RUN, command duty=250 ramps down by 100 with the final step landing exactly on 250, then RUN.
- Reversal: in RUN at 300 with dir=1, command dir=0 duty=300. Ramp to 0, then BR=0 for 10 cycles, FWDREV flips to 0 while duty=0, then ramp back up to 300. CMD_READY=0 throughout.
- Stop: stop command from RUN at 200. Ramp to 0, brake for 10 cycles, then IDLE with M_C=0000. A stop command accepted in IDLE causes no output change.
- Fault: FAULT pulse during RAMP gives M_C=0000 and duty 0 on the next edge. CLR_FAULT while FAULT=1 is ignored. CLR_FAULT after FAULT=0 returns to IDLE. FAULT and CMD_VALID in the same cycle: fault wins and no command is accepted.
- Reset mid-brake: assert RST during BRAKE. Next edge shows M_C=0000, DUTY_VALUE=0, STATE=0, CMD_READY=1.
